// File: rtl/led_fade_pwm.sv
// Per-LED instant-on / linear fade-out brightness, rendered as PWM against a shared counter.
// Define LED_FADE_GAMMA_EN to map level to duty through a squared (approx. gamma-2) curve.
module led_fade_pwm #(
  parameter int LED_COUNT      = 4,
  parameter int PWM_WIDTH      = 8,
  parameter int FADE_DIV_WIDTH = 16,
  parameter int DECAY_STEP     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [LED_COUNT-1:0] i_led,
  output logic [LED_COUNT-1:0] o_led
);

  localparam logic [PWM_WIDTH-1:0] LVL_MAX = '1;
  localparam logic [PWM_WIDTH-1:0] STEP    = PWM_WIDTH'(DECAY_STEP);

  logic [PWM_WIDTH-1:0]      pwm_cnt;
  logic [FADE_DIV_WIDTH-1:0] fade_div;
  logic                      fade_tick;
  logic [PWM_WIDTH-1:0]      level [LED_COUNT];
  logic [LED_COUNT-1:0]      o_led_nxt;

  // Saturating subtract: a released LED bottoms out at 0 instead of wrapping.
  function automatic logic [PWM_WIDTH-1:0] decay(input logic [PWM_WIDTH-1:0] x);
    return (x > STEP) ? (x - STEP) : '0;
  endfunction

  function automatic logic [PWM_WIDTH-1:0] duty(input logic [PWM_WIDTH-1:0] x);
`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_WIDTH-1:0] sq;
    sq = {{PWM_WIDTH{1'b0}}, x} * {{PWM_WIDTH{1'b0}}, x};
    return sq[2*PWM_WIDTH-1:PWM_WIDTH];
`else
    return x;
`endif
  endfunction

  assign fade_tick = &fade_div;

  // Stage: level -> PWM compare (combinational), registered into o_led below.
  always_comb begin
    o_led_nxt = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      o_led_nxt[i] = (level[i] == LVL_MAX) || (duty(level[i]) > pwm_cnt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pwm_cnt  <= '0;
      fade_div <= '0;
      o_led    <= '0;
      for (int i = 0; i < LED_COUNT; i++) begin
        level[i] <= '0;
      end
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      fade_div <= fade_div + 1'b1;
      o_led    <= o_led_nxt;
      // Attack beats a coincident fade tick.
      for (int i = 0; i < LED_COUNT; i++) begin
        if (i_led[i]) begin
          level[i] <= LVL_MAX;
        end else if (fade_tick) begin
          level[i] <= decay(level[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomised + directed bench for led_fade_pwm: three instances with different decay steps
// share one stimulus and are checked every cycle against an arithmetic reference model.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_led;
  logic [3:0] o64, o100, o127;
  logic [3:0] dut_o [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_fade_pwm #(.LED_COUNT(4), .PWM_WIDTH(8), .FADE_DIV_WIDTH(10), .DECAY_STEP(64)) u_d64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_led(i_led), .o_led(o64));
  led_fade_pwm #(.LED_COUNT(4), .PWM_WIDTH(8), .FADE_DIV_WIDTH(10), .DECAY_STEP(100)) u_d100 (
    .i_clk(clk), .i_rst_n(rst_n), .i_led(i_led), .o_led(o100));
  led_fade_pwm #(.LED_COUNT(4), .PWM_WIDTH(8), .FADE_DIV_WIDTH(10), .DECAY_STEP(127)) u_d127 (
    .i_clk(clk), .i_rst_n(rst_n), .i_led(i_led), .o_led(o127));

  assign dut_o[0] = o64;
  assign dut_o[1] = o100;
  assign dut_o[2] = o127;

  // Reference model: brightness levels, cycle position in the PWM period and in the fade period.
  int         dec [3] = '{64, 100, 127};
  int         m_lvl [3][4];
  int         m_pwm;
  int         m_div;
  bit         m_tick;
  logic [3:0] m_exp [3];

  function automatic int duty_m(input int x);
`ifdef LED_FADE_GAMMA_EN
    return (x * x) / 256;
`else
    return x;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pwm = 0;
      m_div = 0;
      for (int k = 0; k < 3; k++) begin
        m_exp[k] = 4'b0000;
        for (int i = 0; i < 4; i++) m_lvl[k][i] = 0;
      end
    end else begin
      m_tick = (m_div == 1023);
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 4; i++) begin
          m_exp[k][i] = (m_lvl[k][i] == 255) || (duty_m(m_lvl[k][i]) > m_pwm);
          if (i_led[i]) m_lvl[k][i] = 255;
          else if (m_tick) m_lvl[k][i] = (m_lvl[k][i] > dec[k]) ? m_lvl[k][i] - dec[k] : 0;
        end
      end
      m_pwm = (m_pwm + 1) % 256;
      m_div = (m_div + 1) % 1024;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_o[k] !== m_exp[k]) begin
          errors++;
          $display("FAIL model_o_led inst%0d t=%0t got %b want %b", k, $time, dut_o[k], m_exp[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic [3:0] pat);
    rst_n = 1'b0;
    i_led = pat;
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("reset_o_led", {o64, o100, o127}, 0);
    end
    rst_n = 1'b1;
  endtask

  int win [3][20];
  int bad;

  initial begin
    rst_n = 1'b0;
    i_led = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    // Reset with all LEDs requested, then release.
    do_reset(4'b1111);
    step(1);
    chk("rst_rel_edge1", o64, 4'b0000);
    step(1);
    chk("rst_rel_edge2", o64, 4'b1111);
    chk("rst_rel_edge2_d100", o100, 4'b1111);
    step(20);

    // Attack latency.
    do_reset(4'b0000);
    step(10);
    i_led = 4'b0001;
    step(1);
    chk("attack_edge_k", o64, 4'b0000);
    step(1);
    chk("attack_edge_k1", o64, 4'b0001);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      step(1);
      if (o64 !== 4'b0001) bad++;
    end
    chk("attack_hold_bad_cycles", bad, 0);

    // Decay / saturation / gamma: high counts per aligned 256-cycle window for LED1.
    do_reset(4'b0010);
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 20; w++) win[k][w] = 0;
    for (int e = 1; e <= 5120; e++) begin
      step(1);
      for (int k = 0; k < 3; k++) win[k][(e - 1) / 256] += int'(dut_o[k][1]);
      if (e == 100) i_led = 4'b0000;
    end
    chk("d64_win1", win[0][1], 256);
    chk("d64_win4", win[0][4], 191);
    chk("d64_win8", win[0][8], 127);
    chk("d64_win12", win[0][12], 63);
    chk("d64_win16", win[0][16], 0);
    chk("d100_win4", win[1][4], 155);
    chk("d100_win8", win[1][8], 55);
    chk("d100_win12", win[1][12], 0);
    chk("d100_win16_nowrap", win[1][16], 0);
`ifdef LED_FADE_GAMMA_EN
    chk("d127_win4_gamma", win[2][4], 64);
    chk("d127_win8_gamma", win[2][8], 0);
`else
    chk("d127_win4_linear", win[2][4], 128);
    chk("d127_win8_linear", win[2][8], 1);
`endif

    // Attack coinciding with a fade tick while level is 55 (DECAY_STEP=100 instance).
    do_reset(4'b0100);
    for (int e = 1; e <= 3073; e++) begin
      step(1);
      if (e == 10) i_led = 4'b0000;
      if (e == 3071) i_led = 4'b0100;
      if (e == 3072) i_led = 4'b0000;
      if (e == 3072) chk("simul_pre_o_led2", o100[2], 1'b0);
    end
    chk("simul_post_o_led2", o100[2], 1'b1);
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      step(1);
      bad += int'(o100[2]);
    end
    chk("simul_full_window", bad, 256);

    // Random patterns with occasional mid-fade resets; model checks every cycle.
    do_reset(4'b0000);
    for (int n = 0; n < 6000; n++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) i_led = 4'($urandom & $urandom);
      rst_n = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    step(4);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
